mult_decomposable_pipe: RTL and testbench

//  Issue/retire stage wrapped around multiplier_decomposable in the posit PE datapath.
//  - Registers operands and the precision mode under a valid/ready handshake.
//  - Retimes the multiplier result through PIPE_STAGES registers.
//  - Packs the result for the active mode into one 64-bit lane-aligned word for the posit normaliser.
//  - Blocks a mode change until all in-flight products have retired (mode fence).

---
 rtl/mult_decomposable_pipe_if.sv | 31 +++
 rtl/mult_decomposable_pipe.sv | 117 +++++++++++
 tb/tb_mult_decomposable_pipe.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_decomposable_pipe_if.sv
// Precision-mode constants and the operand/result handshake bundle
// shared by the decomposable multiplier stage and its users.
package pe_pkg;
    localparam int PRECISION_CONFIG_L = 2;
    localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_32B = 2'd0;
    localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_16B = 2'd1;
    localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_8B  = 2'd2;
endpackage

interface mult_decomposable_pipe_if;
    import pe_pkg::*;
    logic                          in_valid;
    logic                          in_ready;
    logic [PRECISION_CONFIG_L-1:0] in_mode;
    logic [31:0]                   in0;
    logic [31:0]                   in1;
    logic                          out_valid;
    logic                          out_ready;
    logic [PRECISION_CONFIG_L-1:0] out_mode;
    logic [63:0]                   out_data;

    modport master (
        output in_valid, in_mode, in0, in1, out_ready,
        input  in_ready, out_valid, out_mode, out_data
    );

    modport slave (
        input  in_valid, in_mode, in0, in1, out_ready,
        output in_ready, out_valid, out_mode, out_data
    );
endinterface

// File: rtl/mult_decomposable_pipe.sv
// Issue/retire stage around the decomposable multiplier: operand regs,
// retimed result regs, lane packing and a mode fence on in-flight products.
module mult_decomposable_pipe #(
    parameter int EACH_PART_LEN = 8,
    parameter int N_PARTS       = 4,
    parameter int PIPE_STAGES   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    mult_decomposable_pipe_if.slave bus
);
    import pe_pkg::*;

    localparam int W     = EACH_PART_LEN * N_PARTS;
    localparam int HW    = W / 2;
    localparam int PW    = 2 * EACH_PART_LEN;
    localparam int OCC_W = $clog2(PIPE_STAGES + 2);

    logic                          r_v0;
    logic [PRECISION_CONFIG_L-1:0] r_mode0;
    logic [W-1:0]                  r_a;
    logic [W-1:0]                  r_b;

    logic                          r_v    [PIPE_STAGES];
    logic [PRECISION_CONFIG_L-1:0] r_m    [PIPE_STAGES];
    logic [2*W-1:0]                r_d    [PIPE_STAGES];

    logic [OCC_W-1:0]              r_occ;
    logic [PRECISION_CONFIG_L-1:0] r_cur_mode;

    logic           w_adv;
    logic           w_fence;
    logic           w_accept;
    logic           w_retire;
    logic [2*W-1:0] w_pack;

    assign w_adv    = !r_v[PIPE_STAGES-1] || bus.out_ready;
    assign w_fence  = (r_occ != '0) && (bus.in_mode != r_cur_mode);
    assign w_accept = bus.in_valid && bus.in_ready;
    assign w_retire = r_v[PIPE_STAGES-1] && bus.out_ready;

    assign bus.in_ready  = rst && w_adv && !w_fence;
    assign bus.out_valid = r_v[PIPE_STAGES-1];
    assign bus.out_mode  = r_m[PIPE_STAGES-1];
    assign bus.out_data  = r_d[PIPE_STAGES-1];

    // Lane-gated products land in their lane-aligned slot; other modes give 0.
    always_comb begin
        w_pack = '0;
        case (r_mode0)
            PRECISION_CONFIG_32B: begin
                w_pack = {{W{1'b0}}, r_a} * {{W{1'b0}}, r_b};
            end
            PRECISION_CONFIG_16B: begin
                for (int h = 0; h < 2; h++) begin
                    w_pack[2*HW*h +: 2*HW] =
                        {{HW{1'b0}}, r_a[HW*h +: HW]} *
                        {{HW{1'b0}}, r_b[HW*h +: HW]};
                end
            end
            PRECISION_CONFIG_8B: begin
                for (int q = 0; q < N_PARTS; q++) begin
                    w_pack[PW*q +: PW] =
                        {{EACH_PART_LEN{1'b0}}, r_a[EACH_PART_LEN*q +: EACH_PART_LEN]} *
                        {{EACH_PART_LEN{1'b0}}, r_b[EACH_PART_LEN*q +: EACH_PART_LEN]};
                end
            end
            default: w_pack = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v0    <= 1'b0;
            r_mode0 <= PRECISION_CONFIG_32B;
            r_a     <= '0;
            r_b     <= '0;
            for (int i = 0; i < PIPE_STAGES; i++) begin
                r_v[i] <= 1'b0;
                r_m[i] <= PRECISION_CONFIG_32B;
                r_d[i] <= '0;
            end
        end else if (w_adv) begin
            r_v0 <= w_accept;
            if (w_accept) begin
                r_mode0 <= bus.in_mode;
                r_a     <= bus.in0;
                r_b     <= bus.in1;
            end
            r_v[0] <= r_v0;
            r_m[0] <= r_mode0;
            r_d[0] <= w_pack;
            for (int i = 1; i < PIPE_STAGES; i++) begin
                r_v[i] <= r_v[i-1];
                r_m[i] <= r_m[i-1];
                r_d[i] <= r_d[i-1];
            end
        end
    end

    // Occupancy covers the operand regs too, so the fence holds until drained.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_occ      <= '0;
            r_cur_mode <= PRECISION_CONFIG_32B;
        end else begin
            if (w_accept) begin
                r_cur_mode <= bus.in_mode;
            end
            case ({w_accept, w_retire})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_decomposable_pipe.sv
// Bench for mult_decomposable_pipe: fixed vectors, fence/backpressure/reset
// sequences and a randomized stream against a queue-based reference model.
module tb_mult_decomposable_pipe;
    import pe_pkg::*;

    localparam int PS = 1;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    typedef struct {
        logic [1:0]  mode;
        logic [63:0] data;
    } res_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    int   retired;
    int   occ_m;
    logic [1:0] cur_m;
    res_t q[$];
    vec_t tbl[8];

    mult_decomposable_pipe_if bif();

    mult_decomposable_pipe #(
        .EACH_PART_LEN(8),
        .N_PARTS(4),
        .PIPE_STAGES(PS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference product: each lane multiplied as plain unsigned integers.
    function automatic logic [63:0] ref_mul(logic [1:0] m, logic [31:0] a,
                                            logic [31:0] b);
        logic [63:0] r;
        int unsigned x;
        int unsigned y;
        r = 64'd0;
        if (m == PRECISION_CONFIG_32B) begin
            r = 64'(a) * 64'(b);
        end else if (m == PRECISION_CONFIG_16B) begin
            for (int h = 0; h < 2; h++) begin
                x = (a >> (16 * h)) & 32'hFFFF;
                y = (b >> (16 * h)) & 32'hFFFF;
                r = r + (64'(x * y) << (32 * h));
            end
        end else if (m == PRECISION_CONFIG_8B) begin
            for (int k = 0; k < 4; k++) begin
                x = (a >> (8 * k)) & 32'hFF;
                y = (b >> (8 * k)) & 32'hFF;
                r = r + (64'(x * y) << (16 * k));
            end
        end
        return r;
    endfunction

    // Scoreboard: observes handshakes at negedge, ahead of the edge that commits them.
    always @(negedge clk) begin
        res_t e;
        if (!rst) begin
            q.delete();
            occ_m = 0;
            cur_m = PRECISION_CONFIG_32B;
        end else begin
            if (bif.in_valid && bif.out_ready) begin
                chk("in_ready_rule", 64'(bif.in_ready),
                    64'(!(occ_m != 0 && bif.in_mode != cur_m)));
            end
            if (bif.out_valid && bif.out_ready) begin
                retired++;
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_retire: got data %h expected no result",
                             bif.out_data);
                end else begin
                    e = q.pop_front();
                    chk("sb_data", bif.out_data, e.data);
                    chk("sb_mode", 64'(bif.out_mode), 64'(e.mode));
                end
                occ_m--;
            end
            if (bif.in_valid && bif.in_ready) begin
                e.mode = bif.in_mode;
                e.data = ref_mul(bif.in_mode, bif.in0, bif.in1);
                q.push_back(e);
                cur_m = bif.in_mode;
                occ_m++;
            end
            if (occ_m > PS + 1 || occ_m < 0) begin
                n_vec++;
                n_err++;
                $display("FAIL occ_bound: got %0d expected 0..%0d", occ_m, PS + 1);
            end
        end
    end

    task automatic apply_vec(vec_t v, string nm);
        int n;
        int c;
        @(posedge clk); #1;
        bif.in_valid  = 1'b1;
        bif.in_mode   = v.mode;
        bif.in0       = v.a;
        bif.in1       = v.b;
        bif.out_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bif.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_rdy"}, 64'(bif.in_ready), 64'd1);
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
        c = 1;
        @(negedge clk);
        while (!bif.out_valid && c < 12) begin
            @(negedge clk);
            c++;
        end
        chk({nm, "_lat"}, 64'(c), 64'(PS + 1));
        chk({nm, "_data"}, bif.out_data, v.exp);
        chk({nm, "_mode"}, 64'(bif.out_mode), 64'(v.mode));
    endtask

    task automatic drain(string nm);
        int n;
        n = 0;
        @(posedge clk); #1;
        bif.in_valid  = 1'b0;
        bif.out_ready = 1'b1;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk(nm, 64'(q.size()), 64'd0);
    endtask

    initial begin
        int n;
        int idx;
        int stall_acc;
        int ret0;
        int sent;
        int guard;
        logic prev_v;
        logic [63:0] prev_d;
        logic [31:0] bp_a[6];
        logic [31:0] bp_b[6];

        n_vec = 0;
        n_err = 0;
        retired = 0;
        tbl[0] = '{PRECISION_CONFIG_32B, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        tbl[1] = '{PRECISION_CONFIG_16B, 32'h0003_FFFF, 32'h0005_FFFF, 64'h0000_000F_FFFE_0001};
        tbl[2] = '{PRECISION_CONFIG_8B,  32'h02FF_0A01, 32'h03FF_0B01, 64'h0006_FE01_006E_0001};
        tbl[3] = '{PRECISION_CONFIG_32B, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};
        tbl[4] = '{PRECISION_CONFIG_16B, 32'h8000_0002, 32'h0002_0003, 64'h0001_0000_0000_0006};
        tbl[5] = '{2'd3,                 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0};
        tbl[6] = '{PRECISION_CONFIG_8B,  32'h8040_2010, 32'h0202_0202, 64'h0100_0080_0040_0020};
        tbl[7] = '{PRECISION_CONFIG_32B, 32'h0000_FFFF, 32'h0001_0001, 64'h0000_0000_FFFF_FFFF};

        rst           = 1'b0;
        bif.in_valid  = 1'b0;
        bif.in_mode   = PRECISION_CONFIG_32B;
        bif.in0       = 32'd0;
        bif.in1       = 32'd0;
        bif.out_ready = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", 64'(bif.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bif.in_ready), 64'd0);
        chk("rst_out_data", bif.out_data, 64'd0);
        chk("rst_out_mode", 64'(bif.out_mode), 64'(PRECISION_CONFIG_32B));
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(bif.in_ready), 64'd1);

        for (int i = 0; i < 8; i++) begin
            apply_vec(tbl[i], $sformatf("vec%0d", i));
        end
        drain("vec_drain");

        // Fence: two 8B words then a 32B word; the 32B waits for both to retire.
        @(posedge clk); #1;
        bif.in_valid = 1'b1;
        bif.in_mode  = PRECISION_CONFIG_8B;
        bif.in0      = 32'h0102_0304;
        bif.in1      = 32'h0506_0708;
        @(negedge clk);
        chk("fence_a_rdy", 64'(bif.in_ready), 64'd1);
        @(posedge clk); #1;
        bif.in0 = 32'hFFEE_DDCC;
        bif.in1 = 32'h1122_3344;
        @(negedge clk);
        chk("fence_b_rdy", 64'(bif.in_ready), 64'd1);
        @(posedge clk); #1;
        bif.in_mode = PRECISION_CONFIG_32B;
        bif.in0     = 32'hDEAD_BEEF;
        bif.in1     = 32'h0000_1000;
        @(negedge clk);
        chk("fence_block", 64'(bif.in_ready), 64'd0);
        n = 0;
        while (!bif.in_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("fence_wait", 64'(n), 64'(PS + 1));
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
        drain("fence_drain");

        // Backpressure: 6 8B words, downstream stalled for the first 4 cycles.
        for (int i = 0; i < 6; i++) begin
            bp_a[i] = $urandom;
            bp_b[i] = $urandom;
        end
        ret0 = retired;
        idx = 0;
        stall_acc = 0;
        prev_v = 1'b0;
        prev_d = 64'd0;
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 40 && idx < 6; cyc++) begin
            bif.out_ready = (cyc >= 4);
            bif.in_valid  = 1'b1;
            bif.in_mode   = PRECISION_CONFIG_8B;
            bif.in0       = bp_a[idx];
            bif.in1       = bp_b[idx];
            @(negedge clk);
            if (!bif.out_ready) begin
                if (prev_v) begin
                    chk("bp_hold_valid", 64'(bif.out_valid), 64'd1);
                    chk("bp_hold_data", bif.out_data, prev_d);
                end
                prev_v = bif.out_valid;
                prev_d = bif.out_data;
                if (bif.in_ready) stall_acc++;
            end
            if (bif.in_ready) idx++;
            @(posedge clk); #1;
        end
        bif.in_valid = 1'b0;
        chk("bp_stall_accepts_le", 64'(stall_acc <= PS + 1), 64'd1);
        chk("bp_all_sent", 64'(idx), 64'd6);
        drain("bp_drain");
        chk("bp_retired", 64'(retired - ret0), 64'd6);

        // Reset with two products in flight.
        @(posedge clk); #1;
        bif.out_ready = 1'b0;
        bif.in_valid  = 1'b1;
        bif.in_mode   = PRECISION_CONFIG_8B;
        bif.in0       = 32'h1111_1111;
        bif.in1       = 32'h2222_2222;
        @(posedge clk); #1;
        bif.in0 = 32'h3333_3333;
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("t6_out_valid", 64'(bif.out_valid), 64'd0);
        chk("t6_in_ready", 64'(bif.in_ready), 64'd0);
        chk("t6_out_mode", 64'(bif.out_mode), 64'(PRECISION_CONFIG_32B));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        bif.out_ready = 1'b1;
        ret0 = retired;
        repeat (6) @(negedge clk);
        chk("t6_no_retire", 64'(retired - ret0), 64'd0);
        apply_vec(tbl[2], "t6_first");
        drain("t6_drain");

        // Randomized stream with random gaps, modes and downstream stalls.
        sent = 0;
        guard = 0;
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
        while (sent < 300 && guard < 5000) begin
            if (!bif.in_valid && $urandom_range(3) != 0) begin
                bif.in_valid = 1'b1;
                bif.in_mode  = ($urandom_range(15) == 0) ? 2'd3 : 2'($urandom_range(2));
                bif.in0      = $urandom;
                bif.in1      = ($urandom_range(7) == 0) ? 32'hFFFF_FFFF : $urandom;
            end
            bif.out_ready = ($urandom_range(9) < 7);
            @(negedge clk);
            if (bif.in_valid && bif.in_ready) begin
                sent++;
                @(posedge clk); #1;
                bif.in_valid = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
            guard++;
        end
        chk("rand_sent", 64'(sent), 64'd300);
        drain("rand_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
